pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Strobes are combinational from state and inputs; state, wait counters and stall_cnt are registered.
module pipe_hazard_ctrl #(
  parameter int LU_STALL_CYC = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRd_E,
  input  logic             RegWr_E,
  input  logic [4:0]       Rt_E,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic             dmem_req_M,
  input  logic             dmem_ack,
  input  logic             redirect_W,
  output logic             en_PC,
  output logic             en_FD,
  output logic             en_DE,
  output logic             en_EM,
  output logic             en_MW,
  output logic             fl_FD,
  output logic             fl_DE,
  output logic             fl_EM,
  output logic             fl_MW,
  output logic             dmem_kill,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  localparam logic [2:0]  LU_RELOAD = 3'(LU_STALL_CYC - 1);
  localparam logic [15:0] TO_LIMIT  = 16'(MEM_TIMEOUT);

  // Strobe bundles ordered {PC, FD, DE, EM, MW} and {FD, DE, EM, MW}
  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_LU  = 5'b00111;
  localparam logic [4:0] EN_MEM = 5'b00001;
  localparam logic [3:0] FL_NO  = 4'b0000;
  localparam logic [3:0] FL_LU  = 4'b0100;
  localparam logic [3:0] FL_MEM = 4'b0001;
  localparam logic [3:0] FL_ALL = 4'b1111;

  state_t      state, state_nxt;
  logic [2:0]  lu_cnt, lu_cnt_nxt;
  logic [15:0] to_cnt, to_cnt_nxt;
  logic [4:0]  en_v;
  logic [3:0]  fl_v;
  logic        kill_v, err_v;
  logic        hz_lu, hz_mem;

  assign hz_lu  = MemRd_E & RegWr_E & (Rt_E != 5'd0) & ((Rt_E == Rs_D) | (Rt_E == Rt_D));
  assign hz_mem = dmem_req_M & ~dmem_ack;

  always_comb begin
    en_v       = EN_ALL;
    fl_v       = FL_NO;
    kill_v     = 1'b0;
    err_v      = 1'b0;
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    to_cnt_nxt = to_cnt;
    case (state)
      RUN: begin
        if (redirect_W) begin
          fl_v   = FL_ALL;
          kill_v = dmem_req_M;
        end else if (hz_mem) begin
          en_v       = EN_MEM;
          fl_v       = FL_MEM;
          state_nxt  = MEM_WAIT;
          to_cnt_nxt = 16'd1;
        end else if (hz_lu) begin
          en_v = EN_LU;
          fl_v = FL_LU;
          if (LU_STALL_CYC > 1) begin
            state_nxt  = LU_STALL;
            lu_cnt_nxt = LU_RELOAD;
          end
        end
      end
      LU_STALL: begin
        // The stalled consumer is held in ID, so bubbles continue regardless of hz_lu
        if (redirect_W) begin
          fl_v       = FL_ALL;
          kill_v     = dmem_req_M;
          state_nxt  = RUN;
          lu_cnt_nxt = 3'd0;
        end else if (hz_mem) begin
          en_v       = EN_MEM;
          fl_v       = FL_MEM;
          state_nxt  = MEM_WAIT;
          lu_cnt_nxt = 3'd0;
          to_cnt_nxt = 16'd1;
        end else begin
          en_v = EN_LU;
          fl_v = FL_LU;
          if (lu_cnt <= 3'd1) begin
            state_nxt  = RUN;
            lu_cnt_nxt = 3'd0;
          end else begin
            lu_cnt_nxt = lu_cnt - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        // A late ack coinciding with a redirect is dropped; the access is killed instead
        if (redirect_W) begin
          fl_v       = FL_ALL;
          kill_v     = 1'b1;
          state_nxt  = RUN;
          to_cnt_nxt = 16'd0;
        end else if (dmem_ack) begin
          state_nxt  = RUN;
          to_cnt_nxt = 16'd0;
        end else if (to_cnt >= TO_LIMIT) begin
          kill_v     = 1'b1;
          err_v      = 1'b1;
          state_nxt  = RUN;
          to_cnt_nxt = 16'd0;
        end else begin
          en_v       = EN_MEM;
          fl_v       = FL_MEM;
          to_cnt_nxt = to_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt  = RUN;
        lu_cnt_nxt = 3'd0;
        to_cnt_nxt = 16'd0;
      end
    endcase
  end

  // Reset forces every register to bubble and freezes the PC
  assign {en_PC, en_FD, en_DE, en_EM, en_MW} = en_v & {5{rst_n}};
  assign {fl_FD, fl_DE, fl_EM, fl_MW}        = fl_v | {4{~rst_n}};
  assign dmem_kill = kill_v & rst_n;
  assign mem_err   = err_v & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      lu_cnt    <= 3'd0;
      to_cnt    <= 16'd0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
      to_cnt <= to_cnt_nxt;
      if (!en_FD && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance with single-bubble load-use, one with three bubbles.
// Each cycle's expected strobes and stall count are queued at drive time and popped at sample time.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, mem_rd, reg_wr, req, ack, redir;
  logic [4:0] rt_e, rs_d, rt_d;

  logic [4:0]  a_en, b_en;
  logic [3:0]  a_fl, b_fl;
  logic        a_kill, b_kill, a_err, b_err;
  logic [31:0] a_cnt, b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_STALL_CYC(1), .MEM_TIMEOUT(8), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .MemRd_E(mem_rd), .RegWr_E(reg_wr),
    .Rt_E(rt_e), .Rs_D(rs_d), .Rt_D(rt_d),
    .dmem_req_M(req), .dmem_ack(ack), .redirect_W(redir),
    .en_PC(a_en[4]), .en_FD(a_en[3]), .en_DE(a_en[2]), .en_EM(a_en[1]), .en_MW(a_en[0]),
    .fl_FD(a_fl[3]), .fl_DE(a_fl[2]), .fl_EM(a_fl[1]), .fl_MW(a_fl[0]),
    .dmem_kill(a_kill), .mem_err(a_err), .stall_cnt(a_cnt)
  );

  pipe_hazard_ctrl #(.LU_STALL_CYC(3), .MEM_TIMEOUT(8), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .MemRd_E(mem_rd), .RegWr_E(reg_wr),
    .Rt_E(rt_e), .Rs_D(rs_d), .Rt_D(rt_d),
    .dmem_req_M(req), .dmem_ack(ack), .redirect_W(redir),
    .en_PC(b_en[4]), .en_FD(b_en[3]), .en_DE(b_en[2]), .en_EM(b_en[1]), .en_MW(b_en[0]),
    .fl_FD(b_fl[3]), .fl_DE(b_fl[2]), .fl_EM(b_fl[1]), .fl_MW(b_fl[0]),
    .dmem_kill(b_kill), .mem_err(b_err), .stall_cnt(b_cnt)
  );

  typedef enum {IDLE, LU, LUT, R0, NOWR, NORD, MISS} ld_t;

  typedef struct {
    logic       rst_n, mem_rd, reg_wr, req, ack, redir;
    logic [4:0] rt_e, rs_d, rt_d;
    logic [4:0] en;
    logic [3:0] fl;
    logic       kill, err;
    int         cnt;
  } vec_t;

  localparam logic [4:0] E_ALL = 5'b11111, E_LU = 5'b00111, E_MEM = 5'b00001, E_RST = 5'b00000;
  localparam logic [3:0] F_NO = 4'b0000, F_LU = 4'b0100, F_MEM = 4'b0001, F_ALL = 4'b1111;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t v(bit rst, ld_t ld, bit rq, bit ak, bit rd,
                             logic [4:0] en, logic [3:0] fl, bit kill, bit err, int cnt);
    vec_t t;
    t.rst_n = rst; t.req = rq; t.ack = ak; t.redir = rd;
    t.en = en; t.fl = fl; t.kill = kill; t.err = err; t.cnt = cnt;
    {t.mem_rd, t.reg_wr, t.rt_e, t.rs_d, t.rt_d} = {2'b00, 5'd0, 5'd0, 5'd0};
    case (ld)
      LU:   {t.mem_rd, t.reg_wr, t.rt_e, t.rs_d, t.rt_d} = {2'b11, 5'd5, 5'd5, 5'd0};
      LUT:  {t.mem_rd, t.reg_wr, t.rt_e, t.rs_d, t.rt_d} = {2'b11, 5'd7, 5'd3, 5'd7};
      R0:   {t.mem_rd, t.reg_wr, t.rt_e, t.rs_d, t.rt_d} = {2'b11, 5'd0, 5'd0, 5'd0};
      NOWR: {t.mem_rd, t.reg_wr, t.rt_e, t.rs_d, t.rt_d} = {2'b10, 5'd5, 5'd5, 5'd0};
      NORD: {t.mem_rd, t.reg_wr, t.rt_e, t.rs_d, t.rt_d} = {2'b01, 5'd5, 5'd5, 5'd0};
      MISS: {t.mem_rd, t.reg_wr, t.rt_e, t.rs_d, t.rt_d} = {2'b11, 5'd5, 5'd6, 5'd7};
      default: ;
    endcase
    return t;
  endfunction

  task automatic step(input vec_t t, input bit use3, input string tag);
    vec_t       e;
    logic [11:0] act_s, exp_s;
    logic [31:0] act_c;
    @(negedge clk);
    rst_n = t.rst_n; mem_rd = t.mem_rd; reg_wr = t.reg_wr;
    rt_e = t.rt_e; rs_d = t.rs_d; rt_d = t.rt_d;
    req = t.req; ack = t.ack; redir = t.redir;
    exp_q.push_back(t);
    #2;
    e = exp_q.pop_front();
    act_s = use3 ? {b_en, b_fl, b_kill, b_err} : {a_en, a_fl, a_kill, a_err};
    act_c = use3 ? b_cnt : a_cnt;
    exp_s = {e.en, e.fl, e.kill, e.err};
    n_checks++;
    if (act_s !== exp_s) begin
      n_fail++;
      $display("FAIL %s strobes {en,fl,kill,err}: got %b want %b", tag, act_s, exp_s);
    end
    n_checks++;
    if (act_c !== 32'(e.cnt)) begin
      n_fail++;
      $display("FAIL %s stall_cnt: got %0d want %0d", tag, act_c, e.cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {rst_n, mem_rd, reg_wr, req, ack, redir} = '0;
    {rt_e, rs_d, rt_d} = '0;

    // Reset, load-use detection and qualifiers
    tbl.push_back(v(0, IDLE, 0, 0, 0, E_RST, F_ALL, 0, 0, 0));
    tbl.push_back(v(0, LU,   0, 0, 0, E_RST, F_ALL, 0, 0, 0));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 0));
    tbl.push_back(v(1, LU,   0, 0, 0, E_LU,  F_LU,  0, 0, 0));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 1));
    tbl.push_back(v(1, LUT,  0, 0, 0, E_LU,  F_LU,  0, 0, 1));
    tbl.push_back(v(1, R0,   0, 0, 0, E_ALL, F_NO,  0, 0, 2));
    tbl.push_back(v(1, NOWR, 0, 0, 0, E_ALL, F_NO,  0, 0, 2));
    tbl.push_back(v(1, NORD, 0, 0, 0, E_ALL, F_NO,  0, 0, 2));
    tbl.push_back(v(1, MISS, 0, 0, 0, E_ALL, F_NO,  0, 0, 2));
    // Memory wait, ack on the fifth cycle of the request
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(1, IDLE, 1, 0, 0, E_MEM, F_MEM, 0, 0, 2 + i));
    tbl.push_back(v(1, IDLE, 1, 1, 0, E_ALL, F_NO,  0, 0, 6));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 6));
    tbl.push_back(v(1, IDLE, 1, 1, 0, E_ALL, F_NO,  0, 0, 6));
    // Memory beats load-use; load-use re-evaluated after release
    tbl.push_back(v(1, LU,   1, 0, 0, E_MEM, F_MEM, 0, 0, 6));
    tbl.push_back(v(1, LU,   1, 1, 0, E_ALL, F_NO,  0, 0, 7));
    tbl.push_back(v(1, LU,   0, 0, 0, E_LU,  F_LU,  0, 0, 7));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 8));
    // Timeout: eight MEM_WAIT cycles, kill and error on the last
    for (int i = 0; i < 8; i++)
      tbl.push_back(v(1, IDLE, 1, 0, 0, E_MEM, F_MEM, 0, 0, 8 + i));
    tbl.push_back(v(1, IDLE, 1, 0, 0, E_ALL, F_NO,  1, 1, 16));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 16));
    // Redirect wins over memory and load-use hazards
    tbl.push_back(v(1, LU,   1, 0, 1, E_ALL, F_ALL, 1, 0, 16));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 16));
    tbl.push_back(v(1, IDLE, 1, 0, 0, E_MEM, F_MEM, 0, 0, 16));
    tbl.push_back(v(1, IDLE, 1, 1, 1, E_ALL, F_ALL, 1, 0, 17));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 17));
    tbl.push_back(v(1, IDLE, 0, 0, 1, E_ALL, F_ALL, 0, 0, 17));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 17));
    // Reset asserted mid MEM_WAIT, then normal flow
    tbl.push_back(v(1, IDLE, 1, 0, 0, E_MEM, F_MEM, 0, 0, 17));
    tbl.push_back(v(1, IDLE, 1, 0, 0, E_MEM, F_MEM, 0, 0, 18));
    tbl.push_back(v(0, IDLE, 1, 0, 0, E_RST, F_ALL, 0, 0, 0));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 0));
    tbl.push_back(v(1, IDLE, 1, 1, 0, E_ALL, F_NO,  0, 0, 0));
    tbl.push_back(v(1, LU,   0, 0, 0, E_LU,  F_LU,  0, 0, 0));
    tbl.push_back(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 1));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], 1'b0, $sformatf("row%0d", i));

    // Three-bubble load-use on the second instance
    step(v(0, IDLE, 0, 0, 0, E_RST, F_ALL, 0, 0, 0), 1'b1, "lu3_rst");
    step(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 0), 1'b1, "lu3_idle");
    step(v(1, LU,   0, 0, 0, E_LU,  F_LU,  0, 0, 0), 1'b1, "lu3_b1");
    step(v(1, IDLE, 0, 0, 0, E_LU,  F_LU,  0, 0, 1), 1'b1, "lu3_b2");
    step(v(1, IDLE, 0, 0, 0, E_LU,  F_LU,  0, 0, 2), 1'b1, "lu3_b3");
    step(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 3), 1'b1, "lu3_run");
    step(v(1, R0,   0, 0, 0, E_ALL, F_NO,  0, 0, 3), 1'b1, "lu3_r0");
    // Redirect preempts LU_STALL
    step(v(1, LU,   0, 0, 0, E_LU,  F_LU,  0, 0, 3), 1'b1, "lu3_pre_rd");
    step(v(1, IDLE, 0, 0, 1, E_ALL, F_ALL, 0, 0, 4), 1'b1, "lu3_redir");
    step(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 4), 1'b1, "lu3_after_rd");
    // Memory wait preempts LU_STALL
    step(v(1, LU,   0, 0, 0, E_LU,  F_LU,  0, 0, 4), 1'b1, "lu3_pre_mem");
    step(v(1, IDLE, 1, 0, 0, E_MEM, F_MEM, 0, 0, 5), 1'b1, "lu3_mem");
    step(v(1, IDLE, 1, 1, 0, E_ALL, F_NO,  0, 0, 6), 1'b1, "lu3_ack");
    step(v(1, IDLE, 0, 0, 0, E_ALL, F_NO,  0, 0, 6), 1'b1, "lu3_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
